reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer.sv | 154 +++++++++++++++
 tb/tb_reorder_buffer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order retirement of out-of-order completed instructions.
// Macro: ROB_TAG_CHECK_EN enables the sticky allocation tag check (tag_error).
// Ports:
//   clk, reset     - rising-edge clock, synchronous active-high reset
//   valid_in       - renamed instruction offered by rename
//   data_in        - renamed instruction payload (rename_data)
//   ready_in       - combinational: ROB can accept data_in this cycle
//   wb_valid       - functional unit completion strobe
//   wb_tag         - rob_tag of the completing instruction
//   wb_mispredict  - completing branch was mispredicted
//   free_valid     - pd_old returned to the free list (registered pulse)
//   free_preg      - physical register being returned
//   commit_valid   - one instruction retired in the previous cycle
//   mispredict     - flush pulse to rename, map table and free list
//   tag_error      - sticky allocation tag mismatch flag

package reorder_buffer_pkg;
  localparam int unsigned PREG_W = 7;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned OPC_W  = 7;

  typedef struct packed {
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
    logic [TAG_W-1:0]  rob_tag;
    logic [OPC_W-1:0]  opcode;
    logic [4:0]        rd_arch;
    logic [11:0]       imm;
  } rename_data;
endpackage

module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  rename_data        data_in,
  output logic              ready_in,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic              wb_mispredict,
  output logic              free_valid,
  output logic [PREG_W-1:0] free_preg,
  output logic              commit_valid,
  output logic              mispredict,
  output logic              tag_error
);

  localparam int unsigned PTR_W = 4;
  localparam int unsigned CNT_W = 5;

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  done_q;
  logic [DEPTH-1:0]  mispred_q;
  logic [DEPTH-1:0]  dest_q;      // pd_new != 0, i.e. pd_old must be freed
  logic [PREG_W-1:0] pd_old_q [DEPTH];

  logic retire;
  logic flush;
  logic full;
  logic alloc;
  logic wb_hit;

  // Head retirement uses only registered done bits, so a same-cycle writeback
  // to the head cannot retire it until the following cycle.
  assign retire   = valid_q[head] & done_q[head];
  assign flush    = retire & mispred_q[head];
  assign full     = (count == CNT_W'(DEPTH));
  assign ready_in = !full && !flush;
  assign alloc    = valid_in && ready_in;
  assign wb_hit   = wb_valid && valid_q[wb_tag];

  // Pointer, occupancy, status bits and registered retirement outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      valid_q      <= '0;
      done_q       <= '0;
      mispred_q    <= '0;
      dest_q       <= '0;
      commit_valid <= 1'b0;
      free_valid   <= 1'b0;
      free_preg    <= '0;
      mispredict   <= 1'b0;
    end else begin
      commit_valid <= retire;
      free_valid   <= retire && dest_q[head];
      free_preg    <= (retire && dest_q[head]) ? pd_old_q[head] : '0;
      mispredict   <= flush;

      if (wb_hit) begin
        done_q[wb_tag] <= 1'b1;
        if (wb_mispredict) begin
          mispred_q[wb_tag] <= 1'b1;
        end
      end

      if (flush) begin
        // Discard every younger entry; allocation is blocked this cycle.
        head    <= tail;
        count   <= '0;
        valid_q <= '0;
      end else begin
        if (retire) begin
          valid_q[head] <= 1'b0;
          head          <= head + PTR_W'(1);
        end
        if (alloc) begin
          valid_q[tail]   <= 1'b1;
          done_q[tail]    <= 1'b0;
          mispred_q[tail] <= 1'b0;
          dest_q[tail]    <= (data_in.pd_new != '0);
          tail            <= tail + PTR_W'(1);
        end
        count <= count + CNT_W'(alloc) - CNT_W'(retire);
      end
    end
  end

  // Payload storage needs no reset: it is only read behind a valid bit.
  always_ff @(posedge clk) begin
    if (!reset && alloc) begin
      pd_old_q[tail] <= data_in.pd_old;
    end
  end

`ifdef ROB_TAG_CHECK_EN
  // Sticky flag: rename handed us a tag that disagrees with our tail.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_error <= 1'b0;
    end else if (alloc && (data_in.rob_tag != tail)) begin
      tag_error <= 1'b1;
    end
  end

  logic unused_fields;
  assign unused_fields = ^{data_in.opcode, data_in.rd_arch, data_in.imm};
`else
  assign tag_error = 1'b0;

  logic unused_fields;
  assign unused_fields = ^{data_in.rob_tag, data_in.opcode, data_in.rd_arch, data_in.imm};
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic       clk;
  logic       reset;
  logic       valid_in;
  rename_data data_in;
  logic       ready_in;
  logic       wb_valid;
  logic [3:0] wb_tag;
  logic       wb_mispredict;
  logic       free_valid;
  logic [6:0] free_preg;
  logic       commit_valid;
  logic       mispredict;
  logic       tag_error;

  int checks   = 0;
  int failures = 0;

  reorder_buffer #(.DEPTH(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .ready_in     (ready_in),
    .wb_valid     (wb_valid),
    .wb_tag       (wb_tag),
    .wb_mispredict(wb_mispredict),
    .free_valid   (free_valid),
    .free_preg    (free_preg),
    .commit_valid (commit_valid),
    .mispredict   (mispredict),
    .tag_error    (tag_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: program-order queue of in-flight instructions.
  typedef struct packed {
    logic [3:0] tag;
    logic [6:0] pd_new;
    logic [6:0] pd_old;
    logic       done;
    logic       mis;
  } ment_t;

  ment_t      q[$];
  int         m_tail   = 0;
  logic       m_tagerr = 1'b0;
  logic       exp_commit = 1'b0;
  logic       exp_free   = 1'b0;
  logic       exp_mis    = 1'b0;
  logic [6:0] exp_preg   = 7'd0;

  function automatic bit m_flush();
    return (q.size() > 0) && q[0].done && q[0].mis;
  endfunction

  function automatic bit m_ready();
    return (q.size() < 16) && !m_flush();
  endfunction

  function automatic int m_head();
    return (m_tail - q.size() + 16) % 16;
  endfunction

  // Advance model by one clock using current inputs, then clock the DUT.
  task automatic tick();
    bit         acc;
    bit         ret;
    logic       nc;
    logic       nf;
    logic       nm;
    logic [6:0] np;
    ment_t      e;
    acc = valid_in && m_ready();
    ret = (q.size() > 0) && q[0].done;
    nc  = ret;
    nf  = ret && (q[0].pd_new != 7'd0);
    np  = nf ? q[0].pd_old : 7'd0;
    nm  = ret && q[0].mis;
    if (wb_valid) begin
      for (int i = 0; i < q.size(); i++) begin
        if (q[i].tag == wb_tag) begin
          e = q[i];
          e.done = 1'b1;
          if (wb_mispredict) e.mis = 1'b1;
          q[i] = e;
        end
      end
    end
    if (ret) begin
      if (q[0].mis) q.delete();
      else void'(q.pop_front());
    end
    if (acc) begin
`ifdef ROB_TAG_CHECK_EN
      if (int'(data_in.rob_tag) != m_tail) m_tagerr = 1'b1;
`endif
      e.tag    = 4'(m_tail);
      e.pd_new = data_in.pd_new;
      e.pd_old = data_in.pd_old;
      e.done   = 1'b0;
      e.mis    = 1'b0;
      q.push_back(e);
      m_tail = (m_tail + 1) % 16;
    end
    if (reset) begin
      q.delete();
      m_tail   = 0;
      m_tagerr = 1'b0;
      nc = 1'b0; nf = 1'b0; nm = 1'b0; np = 7'd0;
    end
    @(posedge clk);
    #1;
    exp_commit = nc;
    exp_free   = nf;
    exp_preg   = np;
    exp_mis    = nm;
  endtask

  task automatic idle_inputs();
    valid_in      = 1'b0;
    wb_valid      = 1'b0;
    wb_tag        = 4'd0;
    wb_mispredict = 1'b0;
  endtask

  task automatic set_alloc(input logic [6:0] pn, input logic [6:0] po);
    valid_in        = 1'b1;
    data_in.pd_new  = pn;
    data_in.pd_old  = po;
    data_in.rob_tag = 4'(m_tail);
    data_in.opcode  = 7'($urandom);
    data_in.rd_arch = 5'($urandom);
    data_in.imm     = 12'($urandom);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    set_alloc(7'd40, 7'd5);
    tick();
    reset = 1'b0;
    idle_inputs();
    checks++;
    if ({commit_valid, free_valid, free_preg, mispredict} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", {commit_valid, free_valid, free_preg, mispredict});
    end
    checks++;
    if (ready_in !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b want=1", ready_in);
    end
    checks++;
    if ({dut.count, dut.head, dut.tail} !== 13'd0) begin
      failures++; $display("FAIL reset_ptrs count=%0d head=%0d tail=%0d want=0", dut.count, dut.head, dut.tail);
    end
    checks++;
    if (tag_error !== 1'b0) begin
      failures++; $display("FAIL reset_tag_error got=%b want=0", tag_error);
    end
  endtask

  task automatic test_in_order();
    int got[$];
    int cyc[$];
    logic [3:0] wbs [3];
    wbs[0] = 4'd2; wbs[1] = 4'd0; wbs[2] = 4'd1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_alloc(7'(33 + i), 7'(1 + i));
      tick();
    end
    valid_in = 1'b0;
    for (int c = 0; c < 9; c++) begin
      wb_valid = (c < 3);
      wb_tag   = (c < 3) ? wbs[c] : 4'd0;
      tick();
      checks++;
      if ({commit_valid, free_valid, free_preg, mispredict} !== {exp_commit, exp_free, exp_preg, exp_mis}) begin
        failures++;
        $display("FAIL in_order_cycle%0d got=%b want=%b", c, {commit_valid, free_valid, free_preg, mispredict},
                 {exp_commit, exp_free, exp_preg, exp_mis});
      end
      if (free_valid === 1'b1) begin
        got.push_back(int'(free_preg));
        cyc.push_back(c);
      end
    end
    idle_inputs();
    checks++;
    if (got.size() != 3 || got[0] != 1 || got[1] != 2 || got[2] != 3) begin
      failures++; $display("FAIL in_order_sequence got=%p want=1,2,3", got);
    end else begin
      checks++;
      if (cyc[2] - cyc[0] != 2) begin
        failures++; $display("FAIL in_order_consecutive span=%0d want=2", cyc[2] - cyc[0]);
      end
    end
  endtask

  task automatic test_full();
    logic [6:0] po17;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_alloc(7'(64 + i), 7'(10 + i));
      tick();
    end
    valid_in = 1'b0;
    checks++;
    if (ready_in !== 1'b0 || dut.count !== 5'd16) begin
      failures++; $display("FAIL full_ready got=%b count=%0d want ready=0 count=16", ready_in, dut.count);
    end
    wb_valid = 1'b1; wb_tag = 4'd0;
    tick();
    wb_valid = 1'b0;
    set_alloc(7'd99, 7'd99);
    checks++;
    if (ready_in !== 1'b0) begin
      failures++; $display("FAIL full_retiring_ready got=%b want=0", ready_in);
    end
    tick();
    valid_in = 1'b0;
    checks++;
    if (commit_valid !== 1'b1 || free_preg !== 7'd10 || ready_in !== 1'b1) begin
      failures++;
      $display("FAIL full_retire commit=%b preg=%0d ready=%b want 1,10,1", commit_valid, free_preg, ready_in);
    end
    po17 = 7'd77;
    set_alloc(7'd90, po17);
    tick();
    valid_in = 1'b0;
    checks++;
    if (dut.tail !== 4'd1 || dut.count !== 5'd16 || dut.pd_old_q[0] !== po17) begin
      failures++;
      $display("FAIL full_wrap tail=%0d count=%0d slot0=%0d want 1,16,%0d", dut.tail, dut.count, dut.pd_old_q[0], po17);
    end
    checks++;
    if (int'(dut.tail) != m_tail || int'(dut.count) != q.size()) begin
      failures++; $display("FAIL full_model tail=%0d count=%0d want %0d,%0d", dut.tail, dut.count, m_tail, q.size());
    end
  endtask

  task automatic test_mispredict();
    int commits = 0;
    int mis_pulses = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_alloc(7'(40 + i), 7'(20 + i));
      tick();
    end
    valid_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      wb_valid = (i < 4);
      wb_tag   = 4'(i);
      tick();
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_alloc(7'(50 + i), 7'(30 + i));
      tick();
    end
    valid_in = 1'b0;
    for (int c = 0; c < 7; c++) begin
      wb_valid      = (c < 2);
      wb_tag        = (c == 0) ? 4'd5 : 4'd4;
      wb_mispredict = (c == 0);
      checks++;
      if (ready_in !== m_ready()) begin
        failures++; $display("FAIL mis_ready_cycle%0d got=%b want=%b", c, ready_in, m_ready());
      end
      tick();
      checks++;
      if ({commit_valid, free_valid, free_preg, mispredict} !== {exp_commit, exp_free, exp_preg, exp_mis}) begin
        failures++;
        $display("FAIL mis_cycle%0d got=%b want=%b", c, {commit_valid, free_valid, free_preg, mispredict},
                 {exp_commit, exp_free, exp_preg, exp_mis});
      end
      if (commit_valid === 1'b1) commits++;
      if (mispredict === 1'b1) mis_pulses++;
    end
    idle_inputs();
    checks++;
    if (commits != 2 || mis_pulses != 1) begin
      failures++; $display("FAIL mis_counts commits=%0d pulses=%0d want 2,1", commits, mis_pulses);
    end
    checks++;
    if (dut.count !== 5'd0 || dut.head !== 4'd8 || dut.tail !== 4'd8) begin
      failures++; $display("FAIL mis_ptrs count=%0d head=%0d tail=%0d want 0,8,8", dut.count, dut.head, dut.tail);
    end
  endtask

  task automatic test_store();
    do_reset();
    set_alloc(7'd0, 7'd9);
    tick();
    valid_in = 1'b0;
    wb_valid = 1'b1; wb_tag = 4'd0;
    tick();
    wb_valid = 1'b0;
    tick();
    checks++;
    if (commit_valid !== 1'b1 || free_valid !== 1'b0) begin
      failures++; $display("FAIL store_commit commit=%b free=%b want 1,0", commit_valid, free_valid);
    end
    tick();
    checks++;
    if (commit_valid !== 1'b0) begin
      failures++; $display("FAIL store_pulse commit=%b want 0", commit_valid);
    end
  endtask

  task automatic test_tag_check();
    logic want;
`ifdef ROB_TAG_CHECK_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    do_reset();
    for (int i = 0; i < 2; i++) begin
      set_alloc(7'(60 + i), 7'(60 + i));
      tick();
    end
    set_alloc(7'd62, 7'd62);
    data_in.rob_tag = 4'd3;
    tick();
    valid_in = 1'b0;
    checks++;
    if (tag_error !== want) begin
      failures++; $display("FAIL tag_error_set got=%b want=%b", tag_error, want);
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (tag_error !== want || tag_error !== m_tagerr) begin
      failures++; $display("FAIL tag_error_sticky got=%b want=%b", tag_error, want);
    end
    do_reset();
    checks++;
    if (tag_error !== 1'b0) begin
      failures++; $display("FAIL tag_error_clear got=%b want=0", tag_error);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_alloc(7'(70 + i), 7'(40 + i));
      tick();
    end
    valid_in = 1'b0;
    wb_valid = 1'b1; wb_tag = 4'd0;
    tick();
    wb_tag = 4'd1;
    tick();
    reset = 1'b1;
    set_alloc(7'd80, 7'd80);
    wb_valid = 1'b1; wb_tag = 4'd2;
    tick();
    reset = 1'b0;
    idle_inputs();
    checks++;
    if (dut.count !== 5'd0 || ready_in !== 1'b1) begin
      failures++; $display("FAIL reset_mid_state count=%0d ready=%b want 0,1", dut.count, ready_in);
    end
    checks++;
    if ({commit_valid, free_valid, free_preg, mispredict, tag_error} !== 11'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b want=0", {commit_valid, free_valid, free_preg, mispredict, tag_error});
    end
    tick();
    checks++;
    if (commit_valid !== 1'b0 || free_valid !== 1'b0) begin
      failures++; $display("FAIL reset_mid_stale commit=%b free=%b want 0,0", commit_valid, free_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 499) == 0);
      valid_in = ($urandom_range(0, 9) < 6);
      set_alloc(($urandom_range(0, 5) == 0) ? 7'd0 : 7'($urandom), 7'($urandom));
      valid_in = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 15) == 0) data_in.rob_tag = 4'($urandom);
      wb_valid = ($urandom_range(0, 9) < 5);
      if (q.size() > 0 && $urandom_range(0, 3) != 0) wb_tag = q[$urandom_range(0, q.size() - 1)].tag;
      else wb_tag = 4'($urandom);
      wb_mispredict = ($urandom_range(0, 9) == 0);
      checks++;
      if (ready_in !== m_ready()) begin
        failures++; $display("FAIL rand_ready_cycle%0d got=%b want=%b", c, ready_in, m_ready());
      end
      tick();
      checks++;
      if ({commit_valid, free_valid, free_preg, mispredict, tag_error} !==
          {exp_commit, exp_free, exp_preg, exp_mis, m_tagerr}) begin
        failures++;
        $display("FAIL rand_out_cycle%0d got=%b want=%b", c, {commit_valid, free_valid, free_preg, mispredict, tag_error},
                 {exp_commit, exp_free, exp_preg, exp_mis, m_tagerr});
      end
      checks++;
      if (int'(dut.count) != q.size() || int'(dut.head) != m_head()) begin
        failures++;
        $display("FAIL rand_occ_cycle%0d count=%0d head=%0d want %0d,%0d", c, dut.count, dut.head, q.size(), m_head());
      end
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    reset   = 1'b0;
    data_in = '0;
    idle_inputs();
    test_reset();
    test_in_order();
    test_full();
    test_mispredict();
    test_store();
    test_tag_check();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
